// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_by_zero_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, div_by_zero_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, div_by_zero_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up applied when the result is published in END.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    typedef struct packed {
        logic neg_q;
        logic neg_r;
    } fix_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [WIDTH-1:0]     dvd, dvd_nxt;
    logic [WIDTH-1:0]     dvs, dvs_nxt;
    logic [WIDTH-1:0]     rem, rem_nxt;
    fix_t                 fix, fix_nxt;
    logic                 zero, zero_nxt;
    logic [2*WIDTH-1:0]   res_q, res_nxt;
    logic                 rdy_q, rdy_nxt;
    logic                 dbz_q, dbz_nxt;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_abs, op2_abs;
    logic [WIDTH:0]       shifted, trial;
    logic                 q_bit;
    logic [WIDTH-1:0]     q_fix, r_fix;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

    // The dividend register doubles as the quotient: bits shift out the top
    // into the partial remainder while quotient bits shift in at the bottom.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign q_bit   = ~trial[WIDTH];

    assign q_fix = fix.neg_q ? -dvd : dvd;
    assign r_fix = fix.neg_r ? -rem : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            fix   <= '0;
            zero  <= 1'b0;
            res_q <= '0;
            rdy_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dvd   <= dvd_nxt;
            dvs   <= dvs_nxt;
            rem   <= rem_nxt;
            fix   <= fix_nxt;
            zero  <= zero_nxt;
            res_q <= res_nxt;
            rdy_q <= rdy_nxt;
            dbz_q <= dbz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dvd_nxt   = dvd;
        dvs_nxt   = dvs;
        rem_nxt   = rem;
        fix_nxt   = fix;
        zero_nxt  = zero;
        res_nxt   = res_q;
        rdy_nxt   = rdy_q;
        dbz_nxt   = dbz_q;
        unique case (state)
            FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    fix_nxt.neg_q = op1_neg ^ op2_neg;
                    fix_nxt.neg_r = op1_neg;
                    dvd_nxt       = op1_abs;
                    dvs_nxt       = op2_abs;
                    rem_nxt       = '0;
                    cnt_nxt       = '0;
                    if (bus.opdata2_i == '0) begin
                        state_nxt = BYZERO;
                        zero_nxt  = 1'b1;
                    end else begin
                        state_nxt = ON;
                        zero_nxt  = 1'b0;
                    end
                end
            end
            BYZERO: begin
                dvd_nxt   = '0;
                rem_nxt   = '0;
                fix_nxt   = '0;
                state_nxt = END;
            end
            ON: begin
                if (bus.annul_i) begin
                    state_nxt = FREE;
                end else begin
                    rem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dvd_nxt = {dvd[WIDTH-2:0], q_bit};
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state_nxt = END;
                end
            end
            END: begin
                // First END cycle publishes the result even if start_i already
                // dropped, so an un-annulled request always gets a ready pulse.
                if (!rdy_q) begin
                    rdy_nxt = 1'b1;
                    res_nxt = {r_fix, q_fix};
                    dbz_nxt = zero;
                end else if (!bus.start_i) begin
                    state_nxt = FREE;
                    rdy_nxt   = 1'b0;
                    res_nxt   = '0;
                    dbz_nxt   = 1'b0;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    assign bus.result_o      = res_q;
    assign bus.ready_o       = rdy_q;
    assign bus.busy_o        = (state != FREE);
    assign bus.div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit at WIDTH=32 and WIDTH=8 against a longint reference.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus32();
    div_unit_if #(.WIDTH(8))  bus8();

    div_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    div_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   st32   = 0;
    int   st8    = 0;
    logic r32_q  = 1'b0;
    logic r8_q   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Plain signed/unsigned arithmetic on w-bit values; zero divisor gives 0.
    function automatic void ref_div(input int w, input bit s, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [31:0] r);
        longint sa, sb, mask;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        if (sb == 0) begin
            q = '0;
            r = '0;
        end else begin
            q = 32'((sa / sb) & mask);
            r = 32'((sa % sb) & mask);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            r32_q <= 1'b0;
        end else begin
            if (bus32.ready_o && !r32_q) begin
                if (sb32.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ready32 actual=1 required=0");
                end else begin
                    e = sb32.pop_front();
                    chk("res32", bus32.result_o, e.res);
                    chk("dbz32", bus32.div_by_zero_o, e.dbz);
                    chk("lat32", cyc - st32, e.lat);
                end
            end
            r32_q <= bus32.ready_o;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            r8_q <= 1'b0;
        end else begin
            if (bus8.ready_o && !r8_q) begin
                if (sb8.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ready8 actual=1 required=0");
                end else begin
                    e = sb8.pop_front();
                    chk("res8", bus8.result_o, e.res[15:0]);
                    chk("dbz8", bus8.div_by_zero_o, e.dbz);
                    chk("lat8", cyc - st8, e.lat);
                end
            end
            r8_q <= bus8.ready_o;
        end
    end

    task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit drop);
        logic [31:0] q, r;
        exp_t e;
        int n;
        ref_div(32, s, a, b, q, r);
        e.res = {r, q};
        e.dbz = (b == 0);
        e.lat = (b == 0) ? 2 : 33;
        sb32.push_back(e);
        @(negedge clk);
        bus32.signed_div_i = s;
        bus32.opdata1_i    = a;
        bus32.opdata2_i    = b;
        bus32.start_i      = 1'b1;
        st32 = cyc + 1;
        @(negedge clk);
        // operands after the latch edge must not matter
        bus32.opdata1_i    = $urandom;
        bus32.opdata2_i    = $urandom;
        bus32.signed_div_i = ~s;
        chk("busy32", bus32.busy_o, 1);
        if (drop) bus32.start_i = 1'b0;
        n = 0;
        while (!bus32.ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus32.ready_o) begin
            fails++;
            $display("FAIL timeout32 actual=no_ready required=ready");
        end
        for (int i = 0; i < hold; i++) begin
            bus32.annul_i = (i == 0);
            @(negedge clk);
            chk("hold_rdy32", bus32.ready_o, 1);
            chk("hold_res32", bus32.result_o, {r, q});
        end
        bus32.annul_i = 1'b0;
        bus32.start_i = 1'b0;
        @(negedge clk);
        chk("rel_rdy32", bus32.ready_o, 0);
        chk("rel_res32", bus32.result_o, 0);
        chk("rel_dbz32", bus32.div_by_zero_o, 0);
        chk("rel_busy32", bus32.busy_o, 0);
    endtask

    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [31:0] q, r;
        exp_t e;
        int n;
        ref_div(8, s, {24'b0, a}, {24'b0, b}, q, r);
        e.res = {48'b0, r[7:0], q[7:0]};
        e.dbz = (b == 0);
        e.lat = (b == 0) ? 2 : 9;
        sb8.push_back(e);
        @(negedge clk);
        bus8.signed_div_i = s;
        bus8.opdata1_i    = a;
        bus8.opdata2_i    = b;
        bus8.start_i      = 1'b1;
        st8 = cyc + 1;
        @(negedge clk);
        bus8.opdata1_i = 8'($urandom);
        bus8.opdata2_i = 8'($urandom);
        n = 0;
        while (!bus8.ready_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus8.ready_o) begin
            fails++;
            $display("FAIL timeout8 actual=no_ready required=ready");
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_res8", bus8.result_o, {r[7:0], q[7:0]});
        end
        bus8.start_i = 1'b0;
        @(negedge clk);
        chk("rel_rdy8", bus8.ready_o, 0);
        chk("rel_busy8", bus8.busy_o, 0);
    endtask

    function automatic logic [31:0] pick_b();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return $urandom_range(1, 20);
            2:       return 32'd0;
            3:       return -$urandom_range(1, 20);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    initial begin
        bus32.signed_div_i = 0; bus32.opdata1_i = 0; bus32.opdata2_i = 0;
        bus32.start_i = 0; bus32.annul_i = 0;
        bus8.signed_div_i = 0; bus8.opdata1_i = 0; bus8.opdata2_i = 0;
        bus8.start_i = 0; bus8.annul_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_res32", bus32.result_o, 0);
        chk("rst_rdy32", bus32.ready_o, 0);
        chk("rst_busy32", bus32.busy_o, 0);
        chk("rst_dbz32", bus32.div_by_zero_o, 0);
        chk("rst_rdy8", bus8.ready_o, 0);
        rst = 1'b0;

        run32(0, 32'd100, 32'd7, 0, 0);
        run32(1, -32'sd7, 32'd2, 1, 0);
        run32(1, 32'd7, -32'sd2, 0, 0);
        run32(0, 32'd5, 32'd0, 1, 0);

        // annul at iteration 10 must drop the request silently
        @(negedge clk);
        bus32.signed_div_i = 0; bus32.opdata1_i = 32'd1000; bus32.opdata2_i = 32'd3;
        bus32.start_i = 1'b1;
        repeat (10) @(negedge clk);
        bus32.annul_i = 1'b1;
        @(negedge clk);
        chk("annul_busy32", bus32.busy_o, 0);
        chk("annul_rdy32", bus32.ready_o, 0);
        bus32.annul_i = 1'b0;
        bus32.start_i = 1'b0;
        repeat (40) @(negedge clk);
        run32(0, 32'd9, 32'd3, 0, 0);

        // annul in FREE blocks acceptance
        bus32.opdata1_i = 32'd50; bus32.opdata2_i = 32'd5;
        bus32.start_i = 1'b1; bus32.annul_i = 1'b1;
        @(negedge clk);
        chk("annul_free_busy32", bus32.busy_o, 0);
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0;

        run32(1, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0);
        run32(0, 32'd1000, 32'd13, 0, 1);

        // rst mid-ON wins over everything
        @(negedge clk);
        bus32.opdata1_i = 32'd77; bus32.opdata2_i = 32'd5; bus32.start_i = 1'b1;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_on_busy32", bus32.busy_o, 0);
        chk("rst_on_rdy32", bus32.ready_o, 0);
        chk("rst_on_res32", bus32.result_o, 0);
        chk("rst_on_dbz32", bus32.div_by_zero_o, 0);
        rst = 1'b0;
        bus32.start_i = 1'b0;

        run8(0, 8'd200, 8'd3, 0);
        run8(1, 8'h80, 8'd3, 1);
        run8(1, 8'h80, 8'hFF, 0);
        run8(0, 8'd7, 8'd0, 0);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            run32(1'($urandom_range(0, 1)), a, pick_b(), $urandom_range(0, 2), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] b;
            b = pick_b();
            run8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), b[7:0], $urandom_range(0, 1));
        end

        repeat (5) @(negedge clk);
        chk("sb32_drained", sb32.size(), 0);
        chk("sb8_drained", sb8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
